// File: rtl/sad_accum.sv
// sad_accum: block sum-of-absolute-differences accumulator with valid/ready handshakes.
// Define SAD_MAX_EN to add out_max, the largest sample of each block.
module sad_accum #(
    parameter int DW        = 8,
    parameter int BLOCK_LEN = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DW-1:0]                     in_diff,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
`ifdef SAD_MAX_EN
    output logic [DW-1:0]                     out_max,
`endif
    output logic [DW+$clog2(BLOCK_LEN)-1:0]   out_sum
);
    localparam int SW = DW + $clog2(BLOCK_LEN);
    localparam int CW = $clog2(BLOCK_LEN);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [SW-1:0]   acc, acc_nx, sum_nx, ext;
    logic            beat, take, last;

    assign in_ready  = (state != HOLD) || out_ready;
    assign out_valid = (state == HOLD);
    assign beat      = in_valid && in_ready && !flush;
    assign take      = out_valid && out_ready;
    assign last      = cnt == CW'(BLOCK_LEN - 1);
    assign ext       = SW'(in_diff);

`ifdef SAD_MAX_EN
    logic [DW-1:0] mx, mx_nx, omax_nx, mx_new;
    assign mx_new = (in_diff > mx) ? in_diff : mx;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        acc_nx   = acc;
        sum_nx   = out_sum;
`ifdef SAD_MAX_EN
        mx_nx    = mx;
        omax_nx  = out_max;
`endif
        if (flush) begin
            // a pending result survives flush; only the partial block is dropped
            state_nx = (state == HOLD && !take) ? HOLD : IDLE;
            cnt_nx   = '0;
            acc_nx   = '0;
`ifdef SAD_MAX_EN
            mx_nx    = '0;
`endif
        end else if (state == HOLD) begin
            if (take) begin
                state_nx = beat ? ACCUM : IDLE;
                cnt_nx   = beat ? CW'(1) : '0;
                acc_nx   = beat ? ext : '0;
`ifdef SAD_MAX_EN
                mx_nx    = beat ? in_diff : '0;
`endif
            end
        end else if (beat) begin
            state_nx = last ? HOLD : ACCUM;
            cnt_nx   = last ? '0 : cnt + 1'b1;
            acc_nx   = last ? '0 : acc + ext;
            sum_nx   = last ? acc + ext : out_sum;
`ifdef SAD_MAX_EN
            mx_nx    = last ? '0 : mx_new;
            omax_nx  = last ? mx_new : out_max;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            out_sum <= '0;
`ifdef SAD_MAX_EN
            mx      <= '0;
            out_max <= '0;
`endif
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            acc     <= acc_nx;
            out_sum <= sum_nx;
`ifdef SAD_MAX_EN
            mx      <= mx_nx;
            out_max <= omax_nx;
`endif
        end
    end
endmodule

// File: doc/sad_accum.md
SAD_ACCUM -- requirements
Module: sad_accum

Interface
REQ-001 SHALL have parameter DW, default 8, meaning the width of each absolute-difference sample.
REQ-002 SHALL have parameter BLOCK_LEN, default 16, meaning the number of samples summed per block; legal range 2..256.
REQ-003 SHALL derive localparam SW = DW + $clog2(BLOCK_LEN), meaning the result width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, upstream abs-diff sample valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept a sample.
REQ-008 SHALL have port in_diff, input, DW, the unsigned |a-b| sample from the abs-diff stage.
REQ-009 SHALL have port flush, input, 1, synchronous discard of the partial block.
REQ-010 SHALL have port out_valid, output, 1, block sum available.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the sum.
REQ-012 SHALL have port out_sum, output, SW, the registered sum of absolute differences.

Function
REQ-013 SHALL transfer an input beat only in a cycle where in_valid and in_ready are both 1; SHALL transfer an output only in a cycle where out_valid and out_ready are both 1.
REQ-014 SHALL implement states IDLE (count 0, no output), ACCUM (0 < count < BLOCK_LEN), and HOLD (out_valid = 1).
REQ-015 SHALL drive in_ready = 1 in IDLE and ACCUM and in_ready = out_ready in HOLD (combinational from out_ready only).
REQ-016 On an input beat in IDLE or ACCUM, SHALL add in_diff zero-extended to SW bits into the accumulator and increment count.
REQ-017 On the beat making count reach BLOCK_LEN, SHALL load out_sum with accumulator + in_diff, set out_valid the next cycle, clear the accumulator and count, and enter HOLD; latency from the final beat to out_valid is exactly 1 cycle.
REQ-018 SHALL never overflow: SW bits hold BLOCK_LEN * (2^DW - 1).
REQ-019 In HOLD, SHALL keep out_sum and out_valid stable until an output transfer.
REQ-020 On an output transfer with no simultaneous input beat, SHALL clear out_valid next cycle and enter IDLE.
REQ-021 On an output transfer with a simultaneous input beat, SHALL clear out_valid, take that beat as sample 0 of the next block (accumulator = in_diff, count = 1), and enter ACCUM (ACCUM precedence when BLOCK_LEN reached is impossible since BLOCK_LEN >= 2).
REQ-022 flush = 1 SHALL clear the accumulator and count and ignore any same-cycle input beat (in_ready remains per REQ-015); in IDLE/ACCUM it SHALL return to IDLE; in HOLD it SHALL NOT affect out_valid or out_sum.
REQ-023 SHALL contain no combinational path from in_valid or in_diff to any output.

Reset
REQ-024 While rst_n = 0, SHALL force state IDLE, count 0, accumulator 0, out_sum 0, out_valid 0; in_ready SHALL read 1 after reset release.
REQ-025 Reset asserted mid-block or in HOLD SHALL discard all partial and pending results without an output transfer.

Configuration
REQ-026 With macro SAD_MAX_EN defined, SHALL add output port out_max (DW bits) holding the largest in_diff of the block, updated, held, cleared, and reset in lockstep with out_sum (reset value 0; flush clears the running max).
REQ-027 Without SAD_MAX_EN, the out_max port and its logic SHALL be absent and all other behaviour is identical.

Verification (DW=8, BLOCK_LEN=4)
REQ-028 Reset, then samples 10,20,30,40 back-to-back with out_ready=1 -> out_valid high for one cycle one cycle after the 4th beat, out_sum=100.
REQ-029 Samples 255 x4 with out_ready=0 for 5 cycles -> out_sum=1020 held stable, in_ready=0 throughout hold, released on out_ready=1.
REQ-030 Continuous in_valid=1 with samples 1..8 and out_ready=1 -> sums 10 then 26, no dropped beat at the block boundary (REQ-021).
REQ-031 Samples 5,6 then flush, then 1,1,1,1 -> out_sum=4, no output for the flushed partial block.
REQ-032 rst_n pulsed low after 3 samples in ACCUM, and separately while in HOLD -> out_valid=0 and out_sum=0 immediately; next 4 samples of 2 give out_sum=8.
REQ-033 With SAD_MAX_EN, samples 7,200,3,199 -> out_sum=409, out_max=200.
